exec_ctrl: RTL
==============

# exec_ctrl

Multi-cycle execute controller that drives the ALU from the issue side. It accepts one 32-bit instruction per valid/ready handshake and decodes it. It then reads the register file, drives the ALU operand and one-hot operation lines, holds them stable for a per-class number of cycles, and captures the result. Finally it writes the result back to the register file, or to the flags register for `cmp`. The block sits between the fetch stage and the ALU, register file and flags register.

## Interface
- `DIV_CYCLES`, default 4: EXEC cycles held for div/mod (≥1).
- `MUL_CYCLES`, default 2: EXEC cycles held for mul (≥1).
- `clk`  in  1  the only clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  fetch presents `instr`.
- `instr_ready`  out  1  high only in IDLE.
- `instr`  in  32  [31:27] opcode, [26] I, [25:22] rd, [21:18] rs1, [17:14] rs2, [17:16] imm modifier, [15:0] imm.
- `rf_rd_addr1`, `rf_rd_addr2`  out  4  register-file read addresses; the read is combinational.
- `rf_rd_data1`, `rf_rd_data2`  in  32  register-file read data.
- `op1`, `op2`, `imm`  out  32  ALU operands, registered.
- `isImmediate`, `isAdd`, `isSub`, `isCmp`, `isMul`, `isDiv`, `isMod`, `isLsl`, `isLsr`, `isAsr`, `isOr`, `isNot`, `isAnd`, `isMov`  out  1 each  ALU operation lines.
- `aluSel`  out  3  ALU result-mux select.
- `aluResult`  in  32  ALU result.
- `Eq`, `Gt`  in  1  ALU compare outputs.
- `rf_wr_en`  out  1  write-back strobe.
- `rf_wr_addr`  out  4  write-back register.
- `rf_wr_data`  out  32  write-back data.
- `flag_wr`  out  1  flags-register write strobe.
- `flag_eq`, `flag_gt`  out  1  flag values to write.
- `op_done`  out  1  one-cycle retire pulse.
- `illegal`  out  1  one-cycle pulse for an unsupported opcode or modifier.

## Operation
- Opcodes: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 cmp, 6 and, 7 or, 8 not, 9 mov, 10 lsl, 11 lsr, 12 asr, 13 nop. Opcodes 14–31 are illegal.
- `aluSel` mapping:
  - 0: add, sub, cmp
  - 1: mul
  - 2: div, mod
  - 3: mov
  - 4: and, or, not
  - 5: lsl, lsr, asr
- Immediate format (I=1):
  - Modifier 00: sign-extend imm[15:0].
  - Modifier 01: zero-extend imm[15:0].
  - Modifier 10: {imm[15:0], 16'h0}.
  - Modifier 11: illegal.
- Operand selection:
  - `isImmediate` = I. `imm` is driven only when I=1, else 0.
  - `op1` = R[rs1]. `op2` = R[rs2]; `op2` is 0 when I=1.
- FSM states are IDLE, READ, EXEC, WB.
  - IDLE: `instr_ready`=1. The `instr_valid` handshake latches `instr` and moves to READ.
  - READ: decodes the instruction and drives `rf_rd_addr1`=rs1 and `rf_rd_addr2`=rs2. Captures `op1`, `op2` and `imm`.
    - Illegal instruction: pulses `illegal` and `op_done` this cycle, then returns to IDLE.
    - nop: goes to WB.
    - Otherwise: loads the cycle counter with N and goes to EXEC.
  - EXEC: asserts exactly one `is*` line and drives `aluSel`, with the operands held constant.
    - N = `MUL_CYCLES` for mul, `DIV_CYCLES` for div/mod, 1 otherwise.
    - On the last EXEC cycle it captures `aluResult`, `Eq` and `Gt`, then goes to WB.
  - WB: pulses `op_done`, then returns to IDLE.
    - cmp: pulses `flag_wr` with the captured Eq/Gt; no `rf_wr_en`.
    - nop: no writes.
    - Otherwise: pulses `rf_wr_en` with `rf_wr_addr`=rd and `rf_wr_data`=captured result.
- All `is*` lines are 0 outside EXEC. `aluSel` holds its last value outside EXEC.
- Division by zero is passed through to the ALU; the controller does not check for it.

## Timing
- Reset:
  - State is IDLE.
  - `instr_ready` is 0 while `rst` is low and 1 from the first cycle after release.
  - All other outputs are 0, and the captured result and flag registers are 0.
- If `rst` is asserted in any state, the operation is aborted immediately. No `rf_wr_en` or `flag_wr` occurs, even if the state was WB.
- Let T be the handshake edge.
  - READ is cycle T+1.
  - EXEC runs from T+2 to T+1+N.
  - WB is T+2+N.
  - `instr_ready` rises at T+3+N.
- Latency examples:
  - add: WB at T+3, next accept possible at T+4.
  - div with default parameters: WB at T+6.
  - nop: WB at T+2.
  - Illegal: pulses at T+1, ready again at T+2.
- `instr_valid` is ignored outside IDLE. `instr` need not be held after the handshake.
- The ALU path from `op1`/`op2` to `aluResult` is a multicycle path of N cycles.

## Test plan
- **Reset:** drive `rst` low for 2 cycles mid-EXEC of a div. Require all outputs 0, no `rf_wr_en`, and `instr_ready`=1 one cycle after release.
- **add:** R1=5, R2=7, add r3,r1,r2 handshake at T. Require `isAdd`=1 and `aluSel`=0 only at T+2, then `rf_wr_en` with addr 3 and data 12 at T+3. Require `instr_ready`=1 at T+4.
- **Immediate modifiers:** mov r4 with imm 16'h8001.
  - Modifier 00: require `imm`=32'hFFFF8001.
  - Modifier 01: require `imm`=32'h00008001.
  - Modifier 10: require `imm`=32'h80010000.
  - Modifier 11: require an `illegal` pulse at T+1 and no writes.
- **cmp:** R1=9, R2=3, cmp r1,r2. Require `flag_wr`=1 with `flag_eq`=0 and `flag_gt`=1 at T+3, and `rf_wr_en`=0.
- **Multicycle hold:** with `DIV_CYCLES`=4, div 100/7 followed by mod 100/7. Require `isDiv` high for exactly 4 cycles with operands constant, then write data 14. Require `isMod` high for 4 cycles, then write data 2.
- **Back-to-back and illegal:** hold `instr_valid` high with opcodes 13, 20, 10 (lsl 1<<4).
  - nop: `op_done` at T+2 and no writes.
  - Opcode 20: `illegal` and `op_done` pulse.
  - lsl: write data 16.
  - Require exactly one handshake per IDLE cycle.

Source files
------------

// File: rtl/exec_ctrl.sv
// ============================================================================
// exec_ctrl : multi-cycle execute controller (issue -> regfile -> ALU -> WB)
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module exec_ctrl #(
    parameter int DIV_CYCLES = 4,
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [3:0]  rf_rd_addr1,
    output logic [3:0]  rf_rd_addr2,
    input  logic [31:0] rf_rd_data1,
    input  logic [31:0] rf_rd_data2,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic [31:0] imm,
    output logic        isImmediate,
    output logic        isAdd,
    output logic        isSub,
    output logic        isCmp,
    output logic        isMul,
    output logic        isDiv,
    output logic        isMod,
    output logic        isLsl,
    output logic        isLsr,
    output logic        isAsr,
    output logic        isOr,
    output logic        isNot,
    output logic        isAnd,
    output logic        isMov,
    output logic [2:0]  aluSel,
    input  logic [31:0] aluResult,
    input  logic        Eq,
    input  logic        Gt,
    output logic        rf_wr_en,
    output logic [3:0]  rf_wr_addr,
    output logic [31:0] rf_wr_data,
    output logic        flag_wr,
    output logic        flag_eq,
    output logic        flag_gt,
    output logic        op_done,
    output logic        illegal
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_MUL = 5'd2,
                           OP_DIV = 5'd3,  OP_MOD = 5'd4,  OP_CMP = 5'd5,
                           OP_AND = 5'd6,  OP_OR  = 5'd7,  OP_NOT = 5'd8,
                           OP_MOV = 5'd9,  OP_LSL = 5'd10, OP_LSR = 5'd11,
                           OP_ASR = 5'd12, OP_NOP = 5'd13;

    localparam logic [15:0] C_MUL_N = 16'(MUL_CYCLES);
    localparam logic [15:0] C_DIV_N = 16'(DIV_CYCLES);

    function automatic logic bad_instr(input logic [31:0] ins);
        return (ins[31:27] > OP_NOP) || (ins[26] && (ins[17:16] == 2'b11));
    endfunction

    state_t      state_q;
    logic        ready_q;
    logic [4:0]  opc_q;
    logic        imm_en_q;
    logic [1:0]  mod_q;
    logic [15:0] imm_raw_q;
    logic [3:0]  rd_q;
    logic [3:0]  rs1_q;
    logic [3:0]  rs2_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic [31:0] imm_q;
    logic        is_imm_q;
    logic [12:0] is_q;
    logic [2:0]  sel_q;
    logic [15:0] cnt_q;
    logic [31:0] result_q;
    logic        eq_q;
    logic        gt_q;
    logic        wr_en_q;
    logic        flag_wr_q;
    logic        done_q;
    logic        illegal_q;

    logic [31:0] imm_d;
    logic [2:0]  sel_d;
    logic [15:0] cnt_d;

    always_comb begin
        imm_d = 32'h0;
        if (imm_en_q) begin
            case (mod_q)
                2'b00:   imm_d = {{16{imm_raw_q[15]}}, imm_raw_q};
                2'b01:   imm_d = {16'h0, imm_raw_q};
                default: imm_d = {imm_raw_q, 16'h0};
            endcase
        end
    end

    always_comb begin
        sel_d = 3'd0;
        case (opc_q)
            OP_MUL:                 sel_d = 3'd1;
            OP_DIV, OP_MOD:         sel_d = 3'd2;
            OP_MOV:                 sel_d = 3'd3;
            OP_AND, OP_OR, OP_NOT:  sel_d = 3'd4;
            OP_LSL, OP_LSR, OP_ASR: sel_d = 3'd5;
            default:                sel_d = 3'd0;
        endcase
    end

    always_comb begin
        cnt_d = 16'd1;
        if (opc_q == OP_MUL) begin
            cnt_d = C_MUL_N;
        end else if (opc_q == OP_DIV || opc_q == OP_MOD) begin
            cnt_d = C_DIV_N;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b0;
            opc_q     <= 5'd0;
            imm_en_q  <= 1'b0;
            mod_q     <= 2'b00;
            imm_raw_q <= 16'h0;
            rd_q      <= 4'd0;
            rs1_q     <= 4'd0;
            rs2_q     <= 4'd0;
            op1_q     <= 32'h0;
            op2_q     <= 32'h0;
            imm_q     <= 32'h0;
            is_imm_q  <= 1'b0;
            is_q      <= 13'h0;
            sel_q     <= 3'd0;
            cnt_q     <= 16'd0;
            result_q  <= 32'h0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            wr_en_q   <= 1'b0;
            flag_wr_q <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            wr_en_q   <= 1'b0;
            flag_wr_q <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ready_q && instr_valid) begin
                        opc_q     <= instr[31:27];
                        imm_en_q  <= instr[26];
                        rd_q      <= instr[25:22];
                        rs1_q     <= instr[21:18];
                        rs2_q     <= instr[17:14];
                        mod_q     <= instr[17:16];
                        imm_raw_q <= instr[15:0];
                        ready_q   <= 1'b0;
                        // illegal/op_done must be visible during READ itself
                        if (bad_instr(instr)) begin
                            illegal_q <= 1'b1;
                            done_q    <= 1'b1;
                        end
                        state_q <= S_READ;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_READ: begin
                    if (illegal_q) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        op1_q <= rf_rd_data1;
                        op2_q <= imm_en_q ? 32'h0 : rf_rd_data2;
                        imm_q <= imm_d;
                        if (opc_q == OP_NOP) begin
                            done_q  <= 1'b1;
                            state_q <= S_WB;
                        end else begin
                            cnt_q    <= cnt_d;
                            is_q     <= 13'd1 << opc_q;
                            is_imm_q <= imm_en_q;
                            sel_q    <= sel_d;
                            state_q  <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (cnt_q == 16'd1) begin
                        result_q <= aluResult;
                        eq_q     <= Eq;
                        gt_q     <= Gt;
                        is_q     <= 13'h0;
                        is_imm_q <= 1'b0;
                        done_q   <= 1'b1;
                        if (opc_q == OP_CMP) begin
                            flag_wr_q <= 1'b1;
                        end else begin
                            wr_en_q <= 1'b1;
                        end
                        state_q <= S_WB;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign instr_ready = ready_q;
    assign rf_rd_addr1 = rs1_q;
    assign rf_rd_addr2 = rs2_q;
    assign op1         = op1_q;
    assign op2         = op2_q;
    assign imm         = imm_q;
    assign isImmediate = is_imm_q;
    assign isAdd       = is_q[0];
    assign isSub       = is_q[1];
    assign isMul       = is_q[2];
    assign isDiv       = is_q[3];
    assign isMod       = is_q[4];
    assign isCmp       = is_q[5];
    assign isAnd       = is_q[6];
    assign isOr        = is_q[7];
    assign isNot       = is_q[8];
    assign isMov       = is_q[9];
    assign isLsl       = is_q[10];
    assign isLsr       = is_q[11];
    assign isAsr       = is_q[12];
    assign aluSel      = sel_q;
    assign rf_wr_en    = wr_en_q;
    assign rf_wr_addr  = rd_q;
    assign rf_wr_data  = result_q;
    assign flag_wr     = flag_wr_q;
    assign flag_eq     = eq_q;
    assign flag_gt     = gt_q;
    assign op_done     = done_q;
    assign illegal     = illegal_q;

endmodule

`default_nettype wire
